ps2_scan_receiver: RTL and testbench

//  PS/2 device-to-host receiver. Deframes 11-bit keyboard frames from PS2_CLK/PS2_DAT into
//  8-bit scan codes and buffers them in a small show-ahead FIFO. Sits directly upstream of the
//  key input detectors, which consume scan_code/scan_ready and pop entries via a one-cycle read pulse.

---
 rtl/ps2_scan_receiver_if.sv | 46 ++++
 rtl/ps2_scan_receiver.sv | 237 +++++++++++++++++++++++
 tb/tb_ps2_scan_receiver.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/ps2_scan_receiver_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_scan_receiver_if
// Description : Bundle of the PS/2 receive lines and the scan-code consumer
//               handshake for ps2_scan_receiver.
//   PS2_CLK    raw PS/2 clock from the keyboard (asynchronous)
//   PS2_DAT    raw PS/2 data from the keyboard (asynchronous)
//   read       one-cycle pop request from the consumer
//   scan_ready FIFO non-empty
//   scan_code  FIFO head (show-ahead), valid while scan_ready=1
//   frame_err  one-cycle pulse on parity/stop error or inter-bit timeout
//   overflow   sticky, a good frame was dropped on a full FIFO
//   modport slave  : the receiver
//   modport master : keyboard lines plus scan-code consumer
// Revision    : 1.0 - initial release
// ============================================================================
interface ps2_scan_receiver_if;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic       read;
  logic       scan_ready;
  logic [7:0] scan_code;
  logic       frame_err;
  logic       overflow;

  modport slave (
    input  PS2_CLK,
    input  PS2_DAT,
    input  read,
    output scan_ready,
    output scan_code,
    output frame_err,
    output overflow
  );

  modport master (
    output PS2_CLK,
    output PS2_DAT,
    output read,
    input  scan_ready,
    input  scan_code,
    input  frame_err,
    input  overflow
  );
endinterface
`default_nettype wire

// File: rtl/ps2_scan_receiver.sv
`default_nettype none
// ============================================================================
// Module      : ps2_scan_receiver
// Description : PS/2 device-to-host receiver. Synchronizes and glitch-filters
//               PS2_CLK, deframes 11-bit frames (start, 8 data LSB first, odd
//               parity, stop) on falling edges of the filtered clock, checks
//               parity/stop, aborts stalled frames after an inter-bit timeout
//               and buffers good scan codes in a show-ahead FIFO.
// Parameters  : FIFO_DEPTH     scan-code buffer entries (power of 2, >= 2)
//               FILTER_LEN     equal samples needed to accept a PS2_CLK change
//               TIMEOUT_CYCLES CLOCK_50 cycles without a falling edge that
//                              abort a partial frame
// Ports       : CLOCK_50  in  system clock, sole clock domain
//               resetn    in  asynchronous reset, active low
//               bus       ps2_scan_receiver_if.slave
//                 PS2_CLK/PS2_DAT in, read in,
//                 scan_ready/scan_code/frame_err/overflow out
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_scan_receiver #(
  parameter int FIFO_DEPTH     = 4,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  ps2_scan_receiver_if.slave   bus
);

  // --------------------------------------------------------------------------
  // Widths and constants
  // --------------------------------------------------------------------------
  localparam int c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int c_FLT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
  localparam int c_TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(FIFO_DEPTH);
  localparam logic [c_FLT_W-1:0] c_FLT_LAST = c_FLT_W'(FILTER_LEN - 1);
  localparam logic [c_TO_W-1:0]  c_TO_LAST  = c_TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_DATA   = 2'd1;
  localparam logic [1:0] c_PARITY = 2'd2;
  localparam logic [1:0] c_STOP   = 2'd3;

  // --------------------------------------------------------------------------
  // Input synchronizers; idle bus level is high
  // --------------------------------------------------------------------------
  logic r_clk_s1, r_clk_s2;
  logic r_dat_s1, r_dat_s2;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= bus.PS2_CLK;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= bus.PS2_DAT;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // --------------------------------------------------------------------------
  // Clock glitch filter. The counter tracks how many consecutive synchronized
  // samples have disagreed with the current filtered level; since the input
  // is a single bit, disagreeing samples are necessarily identical to each
  // other, so reaching FILTER_LEN of them accepts the new level.
  // --------------------------------------------------------------------------
  logic               r_fclk;
  logic               r_fclk_d;
  logic [c_FLT_W-1:0] r_flt_cnt;
  logic               w_strobe;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_fclk    <= 1'b1;
      r_fclk_d  <= 1'b1;
      r_flt_cnt <= '0;
    end else begin
      r_fclk_d <= r_fclk;
      if (r_clk_s2 == r_fclk) begin
        r_flt_cnt <= '0;
      end else if (r_flt_cnt == c_FLT_LAST) begin
        r_fclk    <= r_clk_s2;
        r_flt_cnt <= '0;
      end else begin
        r_flt_cnt <= r_flt_cnt + c_FLT_W'(1);
      end
    end
  end

  // One-cycle strobe on the falling edge of the filtered clock
  assign w_strobe = r_fclk_d & ~r_fclk;

  // --------------------------------------------------------------------------
  // Frame FSM and inter-bit timeout
  // --------------------------------------------------------------------------
  logic [1:0]        r_state;
  logic [2:0]        r_bitcnt;
  logic [7:0]        r_shift;
  logic              r_parity;
  logic [c_TO_W-1:0] r_to_cnt;
  logic              r_frame_err;
  logic              w_timeout;
  logic              w_stop_ok;
  logic              w_push;
  logic              w_frame_bad;

  // A strobe in the same cycle always wins over the timeout: the bit arrived.
  assign w_timeout = (r_state != c_IDLE) && !w_strobe && (r_to_cnt == c_TO_LAST);

  // Odd parity over data plus parity bit, and a high stop bit
  assign w_stop_ok   = r_dat_s2 & (^{r_shift, r_parity});
  assign w_push      = w_strobe && (r_state == c_STOP) && w_stop_ok;
  assign w_frame_bad = w_strobe && (r_state == c_STOP) && !w_stop_ok;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_to_cnt <= '0;
    end else if ((r_state == c_IDLE) || w_strobe || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + c_TO_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state  <= c_IDLE;
      r_bitcnt <= 3'd0;
      r_shift  <= 8'h00;
      r_parity <= 1'b0;
    end else if (w_timeout) begin
      r_state  <= c_IDLE;
      r_bitcnt <= 3'd0;
      r_shift  <= 8'h00;
    end else if (w_strobe) begin
      case (r_state)
        c_IDLE: begin
          // A high level here is not a start bit; stay put silently
          if (!r_dat_s2) begin
            r_state  <= c_DATA;
            r_bitcnt <= 3'd0;
          end
        end
        c_DATA: begin
          r_shift  <= {r_dat_s2, r_shift[7:1]};
          r_bitcnt <= r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) begin
            r_state <= c_PARITY;
          end
        end
        c_PARITY: begin
          r_parity <= r_dat_s2;
          r_state  <= c_STOP;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_frame_bad | w_timeout;
    end
  end

  // --------------------------------------------------------------------------
  // Show-ahead FIFO
  // --------------------------------------------------------------------------
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_overflow;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_wr;
  logic               w_drop;

  assign w_full  = (r_count == c_FULL);
  assign w_empty = (r_count == '0);
  assign w_pop   = bus.read && !w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_ff @(posedge CLOCK_50) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= r_shift;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs; the head is forced to zero while empty so that the memory,
  // which carries no reset, never shows through.
  // --------------------------------------------------------------------------
  assign bus.scan_ready = !w_empty;
  assign bus.scan_code  = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign bus.frame_err  = r_frame_err;
  assign bus.overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_scan_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_scan_receiver
// Description : Self-checking bench for ps2_scan_receiver. Keyboard frames
//               are driven bit by bit; expected scan codes go into a
//               scoreboard queue and are compared as they are popped.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_scan_receiver;

  localparam int DEPTH   = 4;
  localparam int FLT     = 8;
  localparam int TIMEOUT = 300;
  localparam int HP      = 25;   // PS/2 half period in CLOCK_50 cycles

  logic clk;
  logic resetn;

  ps2_scan_receiver_if bus ();

  ps2_scan_receiver #(
    .FIFO_DEPTH     (DEPTH),
    .FILTER_LEN     (FLT),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) u_dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         err_pulses = 0;
  logic [7:0] sb[$];
  logic       exp_ovf = 1'b0;

  // Every cycle frame_err is high counts, so a stretched pulse shows up too
  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) err_pulses++;
  end

  typedef struct {
    logic [7:0] data;
    bit         good_par;
    bit         stop;
    bit         accept;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Device changes data while the clock is high; host samples on falling edge
  task automatic send_bit(input logic b);
    bus.PS2_DAT = b;
    wait_cyc(HP);
    bus.PS2_CLK = 1'b0;
    wait_cyc(HP);
    bus.PS2_CLK = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit good_par, input bit stop);
    logic par;
    par = good_par ? ~(^d) : (^d);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
    bus.PS2_DAT = 1'b1;
    wait_cyc(2 * HP);
  endtask

  // Scoreboard side of a good frame
  task automatic model_push(input logic [7:0] d);
    if (sb.size() < DEPTH) sb.push_back(d);
    else exp_ovf = 1'b1;
  endtask

  task automatic pop_check(input string name);
    logic [7:0] exp;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got pop request expected empty scoreboard", name);
    end else begin
      exp = sb.pop_front();
      check({name, "_ready"}, 32'(bus.scan_ready), 32'd1);
      check({name, "_code"}, 32'(bus.scan_code), 32'(exp));
      bus.read = 1'b1;
      wait_cyc(1);
      bus.read = 1'b0;
    end
  endtask

  int e0;

  initial begin
    vecs[0] = '{8'h29, 1'b1, 1'b1, 1'b1};
    vecs[1] = '{8'h5A, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h5A, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{8'hF0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b1};
    vecs[5] = '{8'hFF, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{8'h81, 1'b0, 1'b1, 1'b0};

    bus.PS2_CLK = 1'b1;
    bus.PS2_DAT = 1'b1;
    bus.read    = 1'b0;
    resetn      = 1'b0;
    wait_cyc(5);
    check("rst_ready",    32'(bus.scan_ready), 32'd0);
    check("rst_code",     32'(bus.scan_code),  32'd0);
    check("rst_frameerr", 32'(bus.frame_err),  32'd0);
    check("rst_overflow", 32'(bus.overflow),   32'd0);
    resetn = 1'b1;
    wait_cyc(20);

    // Single frames: good ones pop with the right code, bad ones pulse once
    for (int i = 0; i < 7; i++) begin
      e0 = err_pulses;
      send_frame(vecs[i].data, vecs[i].good_par, vecs[i].stop);
      if (vecs[i].accept) model_push(vecs[i].data);
      check($sformatf("vec%0d_err", i), 32'(err_pulses - e0), vecs[i].accept ? 32'd0 : 32'd1);
      check($sformatf("vec%0d_ready", i), 32'(bus.scan_ready), 32'(vecs[i].accept));
      if (vecs[i].accept) begin
        pop_check($sformatf("vec%0d_pop", i));
        check($sformatf("vec%0d_empty", i), 32'(bus.scan_ready), 32'd0);
      end
    end

    // Two frames, no reads: head stays first until popped
    send_frame(8'hF0, 1'b1, 1'b1); model_push(8'hF0);
    send_frame(8'h29, 1'b1, 1'b1); model_push(8'h29);
    check("two_head", 32'(bus.scan_code), 32'hF0);
    pop_check("two_pop0");
    pop_check("two_pop1");
    check("two_empty", 32'(bus.scan_ready), 32'd0);

    // Overflow: fifth frame dropped, flag sticky
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, 1'b1);
      model_push(8'(i));
    end
    check("ovf_set", 32'(bus.overflow), 32'(exp_ovf));
    for (int i = 0; i < DEPTH; i++) pop_check($sformatf("ovf_pop%0d", i));
    check("ovf_empty",  32'(bus.scan_ready), 32'd0);
    check("ovf_sticky", 32'(bus.overflow),   32'd1);

    // Timeout: start + 4 data bits then silence
    e0 = err_pulses;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    bus.PS2_DAT = 1'b1;
    wait_cyc(2 * TIMEOUT);
    check("to_err",   32'(err_pulses - e0), 32'd1);
    check("to_ready", 32'(bus.scan_ready),  32'd0);
    send_frame(8'h1C, 1'b1, 1'b1); model_push(8'h1C);
    pop_check("to_next");

    // Short low glitch with data low must not look like a start bit
    e0 = err_pulses;
    bus.PS2_DAT = 1'b0;
    wait_cyc(HP);
    bus.PS2_CLK = 1'b0;
    wait_cyc(3);
    bus.PS2_CLK = 1'b1;
    wait_cyc(HP);
    bus.PS2_DAT = 1'b1;
    wait_cyc(HP);
    check("gl_ready", 32'(bus.scan_ready), 32'd0);
    send_frame(8'h3C, 1'b1, 1'b1); model_push(8'h3C);
    check("gl_err", 32'(err_pulses - e0), 32'd0);
    pop_check("gl_pop");

    // Reset mid-frame with a buffered byte and overflow set
    send_frame(8'h77, 1'b1, 1'b1);
    e0 = err_pulses;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    bus.PS2_DAT = 1'b0;
    wait_cyc(HP / 2);
    resetn = 1'b0;
    wait_cyc(3);
    check("mr_ready",    32'(bus.scan_ready), 32'd0);
    check("mr_code",     32'(bus.scan_code),  32'd0);
    check("mr_frameerr", 32'(bus.frame_err),  32'd0);
    check("mr_overflow", 32'(bus.overflow),   32'd0);
    sb.delete();
    bus.PS2_DAT = 1'b1;
    wait_cyc(3);
    resetn = 1'b1;
    wait_cyc(2 * HP);
    send_frame(8'h1C, 1'b1, 1'b1); model_push(8'h1C);
    check("mr_err", 32'(err_pulses - e0), 32'd0);
    pop_check("mr_pop");
    check("mr_empty", 32'(bus.scan_ready), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
